// File: rtl/ghash_mult_core.sv
// Single GHASH step for AES-GCM: Y = (X ^ Y_prev) * H in GF(2^128), GCM bit order.
// Optional input pipeline stage (latency 2 instead of 1) when GHASH_CORE_INPUT_REG_EN is defined.
module ghash_mult_core #(
  parameter int NB_DATA = 128
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic [NB_DATA-1:0] o_data_y,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_x_prev,
  input  logic [NB_DATA-1:0] i_h_key,
  input  logic               i_valid
);

  // The reduction constant below is only correct for the 128-bit field.
  generate
    if (NB_DATA != 128) begin : g_bad_width
      $error("ghash_mult_core: NB_DATA must be 128");
    end
  endgenerate

  // R = 0xE1 || 0^120: x^128 folded back as x^7 + x^2 + x + 1 in reflected order.
  localparam logic [NB_DATA-1:0] RED_POLY = {8'hE1, {(NB_DATA-8){1'b0}}};

  // i_valid is a plain update enable: there is no ready, no back-pressure, and
  // every state element loads only on an edge where i_valid is high.
  logic [NB_DATA-1:0] mul_a;
  logic [NB_DATA-1:0] mul_h;
  logic [NB_DATA-1:0] product;
  logic [NB_DATA-1:0] acc_z;
  logic [NB_DATA-1:0] acc_v;

`ifdef GHASH_CORE_INPUT_REG_EN
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] h_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      a_q <= '0;
      h_q <= '0;
    end else if (i_valid) begin
      a_q <= i_data_x ^ i_data_x_prev;
      h_q <= i_h_key;
    end
  end

  assign mul_a = a_q;
  assign mul_h = h_q;
`else
  assign mul_a = i_data_x ^ i_data_x_prev;
  assign mul_h = i_h_key;
`endif

  // Fully unrolled shift-and-add: operand MSB (coefficient of x^0) is consumed first.
  always_comb begin
    acc_z = '0;
    acc_v = mul_h;
    for (int i = 0; i < NB_DATA; i++) begin
      if (mul_a[NB_DATA-1-i]) acc_z = acc_z ^ acc_v;
      if (acc_v[0]) acc_v = (acc_v >> 1) ^ RED_POLY;
      else          acc_v = acc_v >> 1;
    end
    product = acc_z;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_data_y <= '0;
    end else if (i_valid) begin
      o_data_y <= product;
    end
  end

endmodule

// File: tb/tb_ghash_mult_core.sv
// Self-checking bench for ghash_mult_core: directed GCM cases plus randomized
// comparison against a polynomial-arithmetic model of GF(2^128).
module tb_ghash_mult_core;

`ifdef GHASH_CORE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [127:0] ONE   = 128'h80000000_00000000_00000000_00000000;
  localparam logic [127:0] H_KEY = 128'hacbef205_79b4b8eb_ce889bac_8732dad7;

  logic         tb_i_clock;
  logic         i_reset;
  logic [127:0] o_data_y;
  logic [127:0] i_data_x;
  logic [127:0] i_data_x_prev;
  logic [127:0] i_h_key;
  logic         i_valid;

  int tests;
  int fails;

  ghash_mult_core #(.NB_DATA(128)) dut (
    .i_clock      (tb_i_clock),
    .i_reset      (i_reset),
    .o_data_y     (o_data_y),
    .i_data_x     (i_data_x),
    .i_data_x_prev(i_data_x_prev),
    .i_h_key      (i_h_key),
    .i_valid      (i_valid)
  );

  // Clock / reset
  initial tb_i_clock = 1'b0;
  always #5 tb_i_clock = ~tb_i_clock;

  // Reference model: reflect into ordinary polynomial order (bit i = x^i),
  // carry-less multiply to 255 bits, reduce by the field polynomial, reflect back.
  function automatic logic [127:0] reflect(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ra;
    logic [127:0] rb;
    logic [254:0] p;
    logic [254:0] poly;
    ra   = reflect(a);
    rb   = reflect(b);
    p    = '0;
    poly = (255'(1) << 128) | 255'h87;
    for (int i = 0; i < 128; i++)
      if (rb[i]) p = p ^ (255'(ra) << i);
    for (int i = 254; i >= 128; i--)
      if (p[i]) p = p ^ (poly << (i - 128));
    return reflect(p[127:0]);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver tasks
  task automatic drive(input logic [127:0] x, input logic [127:0] prev,
                       input logic [127:0] h, input logic valid);
    i_data_x      = x;
    i_data_x_prev = prev;
    i_h_key       = h;
    i_valid       = valid;
  endtask

  // Waits LAT active edges and lands 1 time unit past the last one.
  task automatic wait_lat();
    repeat (LAT) @(posedge tb_i_clock);
    #1;
  endtask

  task automatic test_reset();
    logic [127:0] exp_v;
    i_reset = 1'b0;
    drive(ONE, '0, H_KEY, 1'b1);
    repeat (2) @(posedge tb_i_clock);
    #1;
    tests++;
    if (o_data_y !== 128'd0) begin
      fails++;
      $display("FAIL reset_initial: got %h expected %h", o_data_y, 128'd0);
    end
    i_reset = 1'b1;
    wait_lat();
    exp_v = H_KEY;
    tests++;
    if (o_data_y !== exp_v) begin
      fails++;
      $display("FAIL reset_release_first_update: got %h expected %h", o_data_y, exp_v);
    end
    // Assert reset mid-cycle, away from any edge.
    #2;
    i_reset = 1'b0;
    #1;
    tests++;
    if (o_data_y !== 128'd0) begin
      fails++;
      $display("FAIL reset_async_clear: got %h expected %h", o_data_y, 128'd0);
    end
    repeat (3) @(posedge tb_i_clock);
    #1;
    tests++;
    if (o_data_y !== 128'd0) begin
      fails++;
      $display("FAIL reset_held: got %h expected %h", o_data_y, 128'd0);
    end
    i_reset = 1'b1;
    #1;
    tests++;
    if (o_data_y !== 128'd0) begin
      fails++;
      $display("FAIL reset_release_before_edge: got %h expected %h", o_data_y, 128'd0);
    end
    wait_lat();
    tests++;
    if (o_data_y !== exp_v) begin
      fails++;
      $display("FAIL reset_resume: got %h expected %h", o_data_y, exp_v);
    end
  endtask

  task automatic test_identity();
    drive(ONE, '0, H_KEY, 1'b1);
    wait_lat();
    tests++;
    if (o_data_y !== H_KEY) begin
      fails++;
      $display("FAIL identity_x: got %h expected %h", o_data_y, H_KEY);
    end
    drive(128'd0, '0, '0, 1'b1);
    wait_lat();
    drive('0, ONE, H_KEY, 1'b1);
    wait_lat();
    tests++;
    if (o_data_y !== H_KEY) begin
      fails++;
      $display("FAIL identity_prev: got %h expected %h", o_data_y, H_KEY);
    end
  endtask

  task automatic test_zero();
    logic [127:0] v;
    v = rand128() | 128'd1;
    drive(v, v, H_KEY, 1'b1);
    wait_lat();
    tests++;
    if (o_data_y !== 128'd0) begin
      fails++;
      $display("FAIL zero_x_eq_prev: got %h expected %h", o_data_y, 128'd0);
    end
    drive(ONE, '0, H_KEY, 1'b1);
    wait_lat();
    drive(rand128() | 128'd1, rand128(), '0, 1'b1);
    wait_lat();
    tests++;
    if (o_data_y !== 128'd0) begin
      fails++;
      $display("FAIL zero_h: got %h expected %h", o_data_y, 128'd0);
    end
  endtask

  task automatic test_hold();
    logic [127:0] a;
    logic [127:0] h;
    logic [127:0] held;
    a = rand128();
    h = rand128();
    drive(a, '0, h, 1'b1);
    wait_lat();
    held = gf_mul(a, h);
    tests++;
    if (o_data_y !== held) begin
      fails++;
      $display("FAIL hold_load: got %h expected %h", o_data_y, held);
    end
    for (int i = 0; i < 4; i++) begin
      drive(rand128(), rand128(), rand128(), 1'b0);
      @(posedge tb_i_clock);
      #1;
      tests++;
      if (o_data_y !== held) begin
        fails++;
        $display("FAIL hold_stable: got %h expected %h", o_data_y, held);
      end
    end
    a = rand128();
    h = rand128();
    drive(a, '0, h, 1'b1);
    wait_lat();
    tests++;
    if (o_data_y !== gf_mul(a, h)) begin
      fails++;
      $display("FAIL hold_resume: got %h expected %h", o_data_y, gf_mul(a, h));
    end
  endtask

  // Five chained GHASH steps: each step's prev is the previous step's output.
  task automatic test_gcm_tc15();
    logic [127:0] blocks[5];
    logic [127:0] y_model;
    logic [127:0] y_prev;
    blocks[0] = 128'h522dc1f0_99567d07_f47f37a3_2a84427d;
    blocks[1] = 128'h643a8cdc_bfe5c0c9_7598a2bd_2555d1aa;
    blocks[2] = 128'h8cb08e48_590dbb3d_a7b08b10_56828838;
    blocks[3] = 128'hc5f61e63_93ba7a0a_bcc9f662_898015ad;
    blocks[4] = 128'h00000000_00000000_00000000_00000200;
    y_model = '0;
    y_prev  = '0;
    for (int i = 0; i < 5; i++) begin
      drive(blocks[i], y_prev, H_KEY, 1'b1);
      wait_lat();
      y_model = gf_mul(blocks[i] ^ y_model, H_KEY);
      tests++;
      if (o_data_y !== y_model) begin
        fails++;
        $display("FAIL tc15_step%0d: got %h expected %h", i, o_data_y, y_model);
      end
      y_prev = o_data_y;
    end
    tests++;
    if (o_data_y !== 128'h4db870d3_7cb75fcb_46097c36_230d1612) begin
      fails++;
      $display("FAIL tc15_final: got %h expected %h", o_data_y,
               128'h4db870d3_7cb75fcb_46097c36_230d1612);
    end
  endtask

  task automatic test_random();
    logic [127:0] exp_q[$];
    logic [127:0] x;
    logic [127:0] p;
    logic [127:0] h;
    logic [127:0] expv;
    for (int n = 0; n < 1000; n++) begin
      x = rand128();
      p = rand128();
      h = rand128();
      case ($urandom_range(0, 15))
        0: h = '0;
        1: p = x;
        2: h = ONE;
        3: begin x = 128'd1; p = '0; end
        default: ;
      endcase
      exp_q.push_back(gf_mul(x ^ p, h));
      drive(x, p, h, 1'b1);
      wait_lat();
      expv = exp_q.pop_front();
      tests++;
      if (o_data_y !== expv) begin
        fails++;
        $display("FAIL random_%0d: got %h expected %h", n, o_data_y, expv);
      end
      drive(h, '0, x ^ p, 1'b1);
      wait_lat();
      tests++;
      if (o_data_y !== expv) begin
        fails++;
        $display("FAIL commute_%0d: got %h expected %h", n, o_data_y, expv);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    i_reset = 1'b0;
    drive('0, '0, '0, 1'b0);
    #3;
    test_reset();
    test_identity();
    test_zero();
    test_hold();
    test_gcm_tc15();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
